// File: rtl/simpsons_door_arbiter_if.sv
// simpsons_door_arbiter_if: request/sensor inputs and grant/status outputs of the door arbiter
interface simpsons_door_arbiter_if;
    logic [1:0] REQ;
    logic [1:0] G;
    logic [1:0] LEVEL;
    logic [1:0] GRANT;
    logic       DOOR_UNLOCK;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;
    logic       TIMEOUT;
    logic       SENSOR_RESET;
    modport master (
        output REQ, G, LEVEL,
        input  GRANT, DOOR_UNLOCK, BUSY, DONE, ERROR, TIMEOUT, SENSOR_RESET
    );
    modport slave (
        input  REQ, G, LEVEL,
        output GRANT, DOOR_UNLOCK, BUSY, DONE, ERROR, TIMEOUT, SENSOR_RESET
    );
endinterface

// File: rtl/simpsons_door_arbiter.sv
// simpsons_door_arbiter: round-robin doorway grant for Bart/Homer with transit tracking and timeout
module simpsons_door_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SETTLE_CYCLES  = 4
) (
    input logic CLK,
    input logic RESET,
    simpsons_door_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT, TRANSIT, SETTLE, CHECK, ABORT} state_t;
    state_t      state;
    logic [1:0]  last;
    logic [1:0]  lv0;
    logic [1:0]  pick;
    logic [15:0] tcnt;
    logic [7:0]  scnt;
    logic        tmo;
    assign pick = (bus.REQ == 2'b11) ? ~last : bus.REQ;
    assign tmo  = (tcnt == 16'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            last             <= 2'b10;
            lv0              <= '0;
            tcnt             <= '0;
            scnt             <= '0;
            bus.GRANT        <= '0;
            bus.DOOR_UNLOCK  <= 1'b0;
            bus.BUSY         <= 1'b0;
            bus.DONE         <= 1'b0;
            bus.ERROR        <= 1'b0;
            bus.TIMEOUT      <= 1'b0;
            bus.SENSOR_RESET <= 1'b0;
        end else begin
            bus.DONE         <= 1'b0;
            bus.ERROR        <= 1'b0;
            bus.TIMEOUT      <= 1'b0;
            bus.SENSOR_RESET <= 1'b0;
            case (state)
                IDLE: if (bus.REQ != 2'b00) begin
                    state           <= WAIT;
                    bus.GRANT       <= pick;
                    bus.DOOR_UNLOCK <= 1'b1;
                    bus.BUSY        <= 1'b1;
                    lv0             <= bus.LEVEL;
                    last            <= pick;
                    tcnt            <= '0;
                end
                WAIT, TRANSIT, SETTLE: begin
                    tcnt <= tcnt + 16'd1;
                    if (tmo) begin
                        state            <= ABORT;
                        bus.TIMEOUT      <= 1'b1;
                        bus.SENSOR_RESET <= 1'b1;
                        bus.GRANT        <= '0;
                        bus.DOOR_UNLOCK  <= 1'b0;
                    end else if (state == WAIT) begin
                        if (bus.G != 2'b00) begin
                            state           <= TRANSIT;
                            bus.DOOR_UNLOCK <= 1'b0;
                        end else if ((bus.REQ & bus.GRANT) == 2'b00) begin
                            state           <= IDLE;
                            bus.GRANT       <= '0;
                            bus.DOOR_UNLOCK <= 1'b0;
                            bus.BUSY        <= 1'b0;
                        end
                    end else if (state == TRANSIT) begin
                        if (bus.G == 2'b00) begin
                            state <= SETTLE;
                            scnt  <= 8'd1;
                        end
                    // the settle count already covers SETTLE_CYCLES quiet cycles, so G is not looked at here
                    end else if (scnt == 8'(SETTLE_CYCLES)) begin
                        state     <= CHECK;
                        bus.DONE  <= ((bus.LEVEL ^ lv0) == bus.GRANT);
                        bus.ERROR <= ((bus.LEVEL ^ lv0) != bus.GRANT);
                        bus.GRANT <= '0;
                    end else if (bus.G != 2'b00) begin
                        state <= TRANSIT;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simpsons_door_arbiter.sv
// tb_simpsons_door_arbiter: table-driven check of grants, transits, settle, error and timeout paths
module tb_simpsons_door_arbiter;
    logic CLK = 1'b0;
    logic RESET;
    int   tests = 0;
    int   fails = 0;
    always #5 CLK = ~CLK;
    simpsons_door_arbiter_if bus();
    simpsons_door_arbiter #(.TIMEOUT_CYCLES(20), .SETTLE_CYCLES(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );
    typedef struct {
        logic       r;
        logic [1:0] req;
        logic [1:0] g;
        logic [1:0] lv;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];
    // packed outputs: {GRANT[1:0], DOOR_UNLOCK, BUSY, DONE, ERROR, TIMEOUT, SENSOR_RESET}
    function automatic logic [7:0] outs();
        return {bus.GRANT, bus.DOOR_UNLOCK, bus.BUSY, bus.DONE, bus.ERROR, bus.TIMEOUT, bus.SENSOR_RESET};
    endfunction
    function automatic void add(int n, logic r, logic [1:0] req, logic [1:0] g, logic [1:0] lv, logic [7:0] exp);
        vec_t v;
        v = '{r, req, g, lv, exp};
        repeat (n) vecs.push_back(v);
    endfunction
    task automatic step(input logic r, input logic [1:0] req, input logic [1:0] g, input logic [1:0] lv,
                        input logic [7:0] exp, input string name);
        RESET   = r;
        bus.REQ = req;
        bus.G   = g;
        bus.LEVEL = lv;
        @(posedge CLK);
        #1;
        tests++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, outs(), exp);
        end
    endtask
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            tests++;
            if (bus.GRANT === 2'b11 || (32'(bus.DONE) + 32'(bus.ERROR) + 32'(bus.TIMEOUT)) > 1) begin
                fails++;
                $display("FAIL invariant: grant %b done %b error %b timeout %b", bus.GRANT, bus.DONE, bus.ERROR, bus.TIMEOUT);
            end
        end
    end
    initial begin
        // Bart alone: grant after 1 cycle, DONE 5 cycles after G returns to 0
        add(1, 1, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000);
        add(1, 0, 2'b01, 2'b00, 2'b00, 8'b01_1_1_0000);
        add(3, 0, 2'b01, 2'b01, 2'b00, 8'b01_0_1_0000);
        add(4, 0, 2'b01, 2'b00, 2'b01, 8'b01_0_1_0000);
        add(1, 0, 2'b00, 2'b00, 2'b01, 8'b00_0_1_1000);
        add(1, 0, 2'b00, 2'b00, 2'b01, 8'b00_0_0_0000);
        // contention with REQ=11 held: 01, 10, 01
        add(1, 1, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000);
        add(1, 0, 2'b11, 2'b00, 2'b00, 8'b01_1_1_0000);
        add(1, 0, 2'b11, 2'b01, 2'b00, 8'b01_0_1_0000);
        add(4, 0, 2'b11, 2'b00, 2'b01, 8'b01_0_1_0000);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'b00_0_1_1000);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'b00_0_0_0000);
        add(1, 0, 2'b11, 2'b00, 2'b01, 8'b10_1_1_0000);
        add(1, 0, 2'b11, 2'b10, 2'b01, 8'b10_0_1_0000);
        add(4, 0, 2'b11, 2'b00, 2'b11, 8'b10_0_1_0000);
        add(1, 0, 2'b11, 2'b00, 2'b11, 8'b00_0_1_1000);
        add(1, 0, 2'b11, 2'b00, 2'b11, 8'b00_0_0_0000);
        add(1, 0, 2'b11, 2'b00, 2'b11, 8'b01_1_1_0000);
        add(1, 0, 2'b11, 2'b01, 2'b11, 8'b01_0_1_0000);
        add(4, 0, 2'b11, 2'b00, 2'b10, 8'b01_0_1_0000);
        add(1, 0, 2'b00, 2'b00, 2'b10, 8'b00_0_1_1000);
        add(1, 0, 2'b00, 2'b00, 2'b10, 8'b00_0_0_0000);
        // wrong outcome: Bart granted but Homer's bit changes
        add(1, 1, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000);
        add(1, 0, 2'b01, 2'b00, 2'b00, 8'b01_1_1_0000);
        add(1, 0, 2'b01, 2'b01, 2'b00, 8'b01_0_1_0000);
        add(4, 0, 2'b01, 2'b00, 2'b10, 8'b01_0_1_0000);
        add(1, 0, 2'b00, 2'b00, 2'b10, 8'b00_0_1_0100);
        add(1, 0, 2'b00, 2'b00, 2'b10, 8'b00_0_0_0000);
        // glitch during settle restarts the quiet count
        add(1, 1, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000);
        add(1, 0, 2'b01, 2'b00, 2'b00, 8'b01_1_1_0000);
        add(1, 0, 2'b01, 2'b01, 2'b00, 8'b01_0_1_0000);
        add(2, 0, 2'b01, 2'b00, 2'b01, 8'b01_0_1_0000);
        add(1, 0, 2'b01, 2'b01, 2'b01, 8'b01_0_1_0000);
        add(4, 0, 2'b01, 2'b00, 2'b01, 8'b01_0_1_0000);
        add(1, 0, 2'b00, 2'b00, 2'b01, 8'b00_0_1_1000);
        add(1, 0, 2'b00, 2'b00, 2'b01, 8'b00_0_0_0000);
        foreach (vecs[i])
            step(vecs[i].r, vecs[i].req, vecs[i].g, vecs[i].lv, vecs[i].exp, $sformatf("vec[%0d]", i));
        // timeout: Homer holds G=10, abort 20 cycles after GRANT rose
        step(1, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000, "to_rst");
        step(0, 2'b10, 2'b00, 2'b00, 8'b10_1_1_0000, "to_grant");
        for (int i = 1; i < 20; i++)
            step(0, 2'b10, 2'b10, 2'b00, 8'b10_0_1_0000, $sformatf("to_hold[%0d]", i));
        step(0, 2'b10, 2'b10, 2'b00, 8'b00_0_1_0011, "to_abort");
        step(0, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000, "to_idle");
        // request dropped in WAIT aborts silently
        step(0, 2'b01, 2'b00, 2'b00, 8'b01_1_1_0000, "ab_grant");
        step(0, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000, "ab_drop");
        step(0, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000, "ab_quiet");
        // G beats a simultaneous request drop, then RESET mid-transit
        step(0, 2'b01, 2'b00, 2'b00, 8'b01_1_1_0000, "gw_grant");
        step(0, 2'b00, 2'b01, 2'b00, 8'b01_0_1_0000, "gw_g_wins");
        step(0, 2'b00, 2'b01, 2'b00, 8'b01_0_1_0000, "rt_transit");
        step(1, 2'b00, 2'b01, 2'b00, 8'b00_0_0_0000, "rt_reset");
        step(0, 2'b00, 2'b00, 2'b00, 8'b00_0_0_0000, "rt_after");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simpsons_door_arbiter.md
Name: simpsons_door_arbiter

Overview:
- Grants use of the single sensed doorway to two requesters: Bart (REQ[0]) and Homer (REQ[1]).
- Only one requester is granted at a time, round-robin on contention. The door is unlocked only for the granted requester.
- Tracks the transit through the G[1:0] gate sensors and checks the outcome against LEVEL from simpsons_sensor.
- On a stuck or abandoned transit, times out and pulses a reset to simpsons_sensor.

Parameters:
- TIMEOUT_CYCLES, 1000, max cycles from grant to transit end before abort; legal range 2..65535.
- SETTLE_CYCLES, 4, consecutive cycles with G==0 needed before a transit counts as finished; legal range 1..255.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  2  level requests; bit0 = Bart, bit1 = Homer.
- G  input  2  raw gate sensors, the same signals that feed simpsons_sensor.
- LEVEL  input  2  occupancy from simpsons_sensor; bit0 = Bart inside, bit1 = Homer inside.
- GRANT  output  2  one-hot grant, or 0 when nothing is granted.
- DOOR_UNLOCK  output  1  door unlocked.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  1-cycle pulse: transit completed correctly.
- ERROR  output  1  1-cycle pulse: transit ended with a wrong LEVEL change.
- TIMEOUT  output  1  1-cycle pulse: transit aborted on timeout.
- SENSOR_RESET  output  1  1-cycle pulse to simpsons_sensor RESET.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: all outputs 0; state IDLE; timeout and settle counters 0; LAST = 2'b10, so Bart wins the first tie.
- All outputs are registered.
- State IDLE:
  - REQ==0: stay in IDLE.
  - One bit set: grant that requester.
  - REQ==2'b11: grant the requester not equal to LAST.
  - On a grant, next cycle GRANT = the one-hot value and DOOR_UNLOCK = 1; capture LEVEL into LV0; update LAST; go to WAIT.
  - Latency from REQ to GRANT is 1 cycle.
- State WAIT (door unlocked):
  - G != 0: go to TRANSIT and drop DOOR_UNLOCK; GRANT holds.
  - Granted REQ bit deasserted while G==0: abort to IDLE, clear GRANT and DOOR_UNLOCK, no pulse.
  - If G != 0 and the REQ drop happen in the same cycle, G wins.
- State TRANSIT:
  - Stay while G != 0; G==3 is legal here.
  - G==0: go to SETTLE with the settle counter at 1.
- State SETTLE:
  - Each cycle with G==0 increments the settle counter.
  - Any G != 0: back to TRANSIT and clear the settle counter.
  - When the settle counter reaches SETTLE_CYCLES, go to CHECK.
- State CHECK (1 cycle): compute D = LEVEL XOR LV0.
  - D == GRANT: DONE pulse.
  - Otherwise, including D==0 (walked back out): ERROR pulse.
  - Either way, clear GRANT and return to IDLE. The pulse and GRANT=0 appear in the same cycle.
- Timeout:
  - Counter clears on grant and increments every cycle in WAIT, TRANSIT and SETTLE.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ABORT. This overrides any other transition that cycle.
- State ABORT (1 cycle): TIMEOUT=1, SENSOR_RESET=1, GRANT=0, DOOR_UNLOCK=0; then IDLE.
- Requests are not sampled in CHECK or ABORT. A held request is granted from IDLE, at earliest 2 cycles after the DONE, ERROR or TIMEOUT pulse.
- RESET mid-transit: immediate return to reset values. SENSOR_RESET is not pulsed; the system drives simpsons_sensor RESET separately.
- At most one of DONE, ERROR and TIMEOUT is high in any cycle. GRANT is never 2'b11.

Test Plan:
- Bart alone: REQ=01 at cycle 0 → GRANT=01 and DOOR_UNLOCK=1 at cycle 1. Then drive G=01 for 3 cycles, G=00, and LEVEL 00→01 → DONE pulse exactly SETTLE_CYCLES+1 cycles after G returns to 0; GRANT=00.
- Contention: REQ=11 held after reset → grants in order 01, 10, 01, each transit completed correctly; LAST alternates.
- Timeout: TIMEOUT_CYCLES=20, grant Homer, hold G=10 → TIMEOUT and SENSOR_RESET high together 20 cycles after GRANT rose; GRANT=00 at the same cycle.
- Wrong outcome: grant Bart, drive a transit while LEVEL changes 00→10 → ERROR pulse, no DONE.
- Glitch in settle: G returns to 00 for 2 cycles, then 01, then 00 for 4 cycles → exactly one DONE, after the final 4 zeros.
- Abort and reset: grant, drop REQ in WAIT → IDLE next cycle with no pulse. Separately, assert RESET in TRANSIT → all outputs 0 next cycle.
